axi4lite_protocol_monitor: RTL and testbench



---
 rtl/axi4lite_protocol_monitor.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axi4lite_protocol_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_protocol_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : axi4lite_protocol_monitor
//  Purpose  : Passive AXI4-lite protocol monitor. It watches all five channels
//             between a master and a slave and never drives the bus. It checks:
//               - handshake stability (payload held, VALID held while stalled)
//               - response ordering against outstanding-transaction counts
//               - outstanding-count overflow
//               - VALID-without-READY stall timeouts
//             Violations set sticky per-rule flags. The monitor also captures
//             a first-error code and keeps a saturating count of error cycles.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             AW*/W*/B*/AR*/R* inputs   - tapped AXI4-lite channel signals
//             err_clr                   - clear all error state
//             err_flags[13:0]           - sticky rule flags
//             first_err_valid/_code     - lowest rule index of first error cycle
//             err_count[CNT_W-1:0]      - saturating count of error cycles
//  Revision : 1.0 - initial release
// ============================================================================
module axi4lite_protocol_monitor #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int MAX_OUTST = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   AWVALID,
    input  logic                   AWREADY,
    input  logic [ADDRWIDTH-1:0]   AWADDR,
    input  logic                   WVALID,
    input  logic                   WREADY,
    input  logic [DATAWIDTH-1:0]   WDATA,
    input  logic [DATAWIDTH/8-1:0] WSTRB,
    input  logic                   BVALID,
    input  logic                   BREADY,
    input  logic [1:0]             BRESP,
    input  logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [ADDRWIDTH-1:0]   ARADDR,
    input  logic                   RVALID,
    input  logic                   RREADY,
    input  logic [DATAWIDTH-1:0]   RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   err_clr,
    output logic [13:0]            err_flags,
    output logic                   first_err_valid,
    output logic [3:0]             first_err_code,
    output logic [CNT_W-1:0]       err_count
);

    localparam int STRBW  = DATAWIDTH / 8;
    localparam int OW     = $clog2(MAX_OUTST + 1);
    localparam int SW     = $clog2(TIMEOUT + 1);
    localparam int NCH    = 5;
    localparam int NRULE  = 14;

    localparam logic [OW-1:0]    C_MAX_OUTST = OW'(MAX_OUTST);
    localparam logic [SW-1:0]    C_TIMEOUT   = SW'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    localparam int C_R_B_UNEXP = 10;
    localparam int C_R_R_UNEXP = 11;
    localparam int C_R_OVF     = 12;
    localparam int C_R_TMO     = 13;

    // Channel order: 0=AW, 1=W, 2=B, 3=AR, 4=R. Rule 2*i is PAYLOAD_CHG and
    // rule 2*i+1 is VALID_DROP for channel i.
    logic [NCH-1:0] w_valid;
    logic [NCH-1:0] w_ready;
    assign w_valid = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
    assign w_ready = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

    // ------------------------------------------------------------------
    // History: payload copies and the first-cycle-after-reset qualifier
    // ------------------------------------------------------------------
    logic                 hist_ok_q;
    logic [ADDRWIDTH-1:0] awaddr_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [STRBW-1:0]     wstrb_q;
    logic [1:0]           bresp_q;
    logic [ADDRWIDTH-1:0] araddr_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic [1:0]           rresp_q;

    // Copies are taken every cycle. They are only consulted when the channel
    // was pending, and then they hold the payload presented while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_ok_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            hist_ok_q <= 1'b1;
            awaddr_q  <= AWADDR;
            wdata_q   <= WDATA;
            wstrb_q   <= WSTRB;
            bresp_q   <= BRESP;
            araddr_q  <= ARADDR;
            rdata_q   <= RDATA;
            rresp_q   <= RRESP;
        end
    end

    logic [NCH-1:0] w_chg;
    assign w_chg[0] = (AWADDR != awaddr_q);
    assign w_chg[1] = ({WDATA, WSTRB} != {wdata_q, wstrb_q});
    assign w_chg[2] = (BRESP != bresp_q);
    assign w_chg[3] = (ARADDR != araddr_q);
    assign w_chg[4] = ({RDATA, RRESP} != {rdata_q, rresp_q});

    // ------------------------------------------------------------------
    // Per-channel pending bit and stall counter
    // ------------------------------------------------------------------
    logic [NCH-1:0] w_pay_err;
    logic [NCH-1:0] w_drop_err;
    logic [NCH-1:0] w_tmo;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic          pend_q;
        logic [SW-1:0] stall_q;
        logic [SW-1:0] stall_d;

        always_comb begin
            stall_d = '0;
            if (w_valid[i] && !w_ready[i]) begin
                stall_d = (stall_q == C_TIMEOUT) ? stall_q : stall_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q  <= 1'b0;
                stall_q <= '0;
            end else begin
                pend_q  <= w_valid[i] & ~w_ready[i];
                stall_q <= stall_d;
            end
        end

        assign w_pay_err[i]  = hist_ok_q & pend_q & w_chg[i];
        assign w_drop_err[i] = hist_ok_q & pend_q & ~w_valid[i];
        // Fires only on the transition into the saturated value, so a
        // stall that persists beyond TIMEOUT is reported once.
        assign w_tmo[i]      = (stall_d == C_TIMEOUT) && (stall_q != C_TIMEOUT);
    end

    // ------------------------------------------------------------------
    // Outstanding-transaction counters
    // ------------------------------------------------------------------
    logic [OW-1:0] aw_out_q, aw_out_d;
    logic [OW-1:0] w_out_q,  w_out_d;
    logic [OW-1:0] ar_out_q, ar_out_d;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID  & WREADY;
    assign w_b_hs  = BVALID  & BREADY;
    assign w_ar_hs = ARVALID & ARREADY;
    assign w_r_hs  = RVALID  & RREADY;

    // A response with nothing outstanding does not decrement; this keeps the
    // counter at zero and lets a simultaneous request still count up.
    function automatic logic [OW-1:0] f_cnt_next(input logic [OW-1:0] cnt,
                                                 input logic          inc,
                                                 input logic          dec);
        logic dec_eff;
        dec_eff = dec && (cnt != '0);
        if (inc && !dec_eff) begin
            f_cnt_next = (cnt == C_MAX_OUTST) ? cnt : cnt + 1'b1;
        end else if (!inc && dec_eff) begin
            f_cnt_next = cnt - 1'b1;
        end else begin
            f_cnt_next = cnt;
        end
    endfunction

    function automatic logic f_ovf(input logic [OW-1:0] cnt,
                                   input logic          inc,
                                   input logic          dec);
        f_ovf = inc && (cnt == C_MAX_OUTST) && !(dec && (cnt != '0));
    endfunction

    always_comb begin
        aw_out_d = f_cnt_next(aw_out_q, w_aw_hs, w_b_hs);
        w_out_d  = f_cnt_next(w_out_q,  w_w_hs,  w_b_hs);
        ar_out_d = f_cnt_next(ar_out_q, w_ar_hs, w_r_hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_out_q <= '0;
            w_out_q  <= '0;
            ar_out_q <= '0;
        end else begin
            aw_out_q <= aw_out_d;
            w_out_q  <= w_out_d;
            ar_out_q <= ar_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Rule detection for the current cycle
    // ------------------------------------------------------------------
    logic [NRULE-1:0] w_det;
    logic             w_any;
    logic [3:0]       w_code;

    always_comb begin
        w_det = '0;
        for (int i = 0; i < NCH; i++) begin
            w_det[2*i]     = w_pay_err[i];
            w_det[2*i + 1] = w_drop_err[i];
        end
        w_det[C_R_B_UNEXP] = BVALID && ((aw_out_q == '0) || (w_out_q == '0));
        w_det[C_R_R_UNEXP] = RVALID && (ar_out_q == '0);
        w_det[C_R_OVF]     = f_ovf(aw_out_q, w_aw_hs, w_b_hs)
                           | f_ovf(w_out_q,  w_w_hs,  w_b_hs)
                           | f_ovf(ar_out_q, w_ar_hs, w_r_hs);
        w_det[C_R_TMO]     = |w_tmo;
    end

    assign w_any = |w_det;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_code = '0;
        for (int i = NRULE - 1; i >= 0; i--) begin
            if (w_det[i]) begin
                w_code = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Error state. A clear wipes the old state but detections from the same
    // cycle are applied on top, so nothing seen during a clear is lost.
    // ------------------------------------------------------------------
    logic [NRULE-1:0] flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, w_cnt_base;
    logic             fv_q, fv_d;
    logic [3:0]       fc_q, fc_d;

    always_comb begin
        flags_d    = (err_clr ? '0 : flags_q) | w_det;
        w_cnt_base = err_clr ? '0 : cnt_q;
        cnt_d      = w_cnt_base;
        if (w_any && (w_cnt_base != C_CNT_MAX)) begin
            cnt_d = w_cnt_base + 1'b1;
        end
        fv_d = err_clr ? 1'b0 : fv_q;
        fc_d = err_clr ? 4'd0 : fc_q;
        if (!fv_d && w_any) begin
            fv_d = 1'b1;
            fc_d = w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            fc_q    <= fc_d;
        end
    end

    assign err_flags       = flags_q;
    assign err_count       = cnt_q;
    assign first_err_valid = fv_q;
    assign first_err_code  = fc_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_protocol_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4lite_protocol_monitor
//  Purpose  : Directed self-checking bench for axi4lite_protocol_monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi4lite_protocol_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;
    logic        err_clr;
    logic [13:0] err_flags;
    logic        first_err_valid;
    logic [3:0]  first_err_code;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi4lite_protocol_monitor #(
        .ADDRWIDTH(32), .DATAWIDTH(32), .MAX_OUTST(4), .TIMEOUT(16), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .err_clr(err_clr), .err_flags(err_flags),
        .first_err_valid(first_err_valid), .first_err_code(first_err_code),
        .err_count(err_count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        AWVALID = 0; AWREADY = 0; AWADDR = 0;
        WVALID = 0; WREADY = 0; WDATA = 0; WSTRB = 0;
        BVALID = 0; BREADY = 0; BRESP = 0;
        ARVALID = 0; ARREADY = 0; ARADDR = 0;
        RVALID = 0; RREADY = 0; RDATA = 0; RRESP = 0;
        err_clr = 0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        // dirty the state, then reset again
        RVALID = 1; RREADY = 1;
        cyc();
        idle_bus();
        do_reset();
        n_tests++; if (err_flags !== 14'h0) begin n_fail++; $display("FAIL reset_flags got %h exp 0000", err_flags); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", err_count); end
        n_tests++; if (first_err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fev got %b exp 0", first_err_valid); end
        n_tests++; if (first_err_code !== 4'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", first_err_code); end
        n_tests++; if (dut.ar_out_q !== 3'd0) begin n_fail++; $display("FAIL reset_ar_out got %0d exp 0", dut.ar_out_q); end
    endtask

    task automatic test_legal_write();
        do_reset();
        cyc();
        AWVALID = 1; AWREADY = 1; AWADDR = 32'h100;
        WVALID = 1; WREADY = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF;
        cyc();
        idle_bus();
        n_tests++; if (dut.aw_out_q !== 3'd1 || dut.w_out_q !== 3'd1) begin n_fail++; $display("FAIL write_outst got aw=%0d w=%0d exp 1 1", dut.aw_out_q, dut.w_out_q); end
        cyc();
        BVALID = 1; BREADY = 1; BRESP = 2'b00;
        cyc();
        idle_bus();
        cyc();
        n_tests++; if (err_flags !== 14'h0) begin n_fail++; $display("FAIL write_flags got %h exp 0000", err_flags); end
        n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL write_count got %0d exp 0", err_count); end
        n_tests++; if (dut.aw_out_q !== 3'd0 || dut.w_out_q !== 3'd0) begin n_fail++; $display("FAIL write_drain got aw=%0d w=%0d exp 0 0", dut.aw_out_q, dut.w_out_q); end
    endtask

    task automatic test_payload_chg();
        do_reset();
        AWVALID = 1; AWREADY = 0; AWADDR = 32'h10;
        cyc();
        AWADDR = 32'h14;
        cyc();
        n_tests++; if (err_flags !== 14'h0001) begin n_fail++; $display("FAIL aw_chg_flags got %h exp 0001", err_flags); end
        n_tests++; if (first_err_code !== 4'd0 || first_err_valid !== 1'b1) begin n_fail++; $display("FAIL aw_chg_code got %0d/%b exp 0/1", first_err_code, first_err_valid); end
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL aw_chg_count got %0d exp 1", err_count); end
        // a later error must not replace the captured code
        AWREADY = 1;
        cyc();
        idle_bus();
        ARVALID = 1; ARREADY = 0; ARADDR = 32'h40;
        cyc();
        ARVALID = 0;
        cyc();
        n_tests++; if (err_flags !== 14'h0081) begin n_fail++; $display("FAIL sticky_flags got %h exp 0081", err_flags); end
        n_tests++; if (first_err_code !== 4'd0 || err_count !== 8'd2) begin n_fail++; $display("FAIL sticky_code got %0d/%0d exp 0/2", first_err_code, err_count); end
    endtask

    task automatic test_valid_drop();
        do_reset();
        WVALID = 1; WREADY = 0; WDATA = 32'h1234; WSTRB = 4'h3;
        cyc();
        WVALID = 0;
        cyc();
        n_tests++; if (err_flags !== 14'h0008) begin n_fail++; $display("FAIL w_drop_flags got %h exp 0008", err_flags); end
        n_tests++; if (first_err_code !== 4'd3 || err_count !== 8'd1) begin n_fail++; $display("FAIL w_drop_code got %0d/%0d exp 3/1", first_err_code, err_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        ARVALID = 1; ARREADY = 0; ARADDR = 32'h200;
        for (int k = 0; k < 15; k++) cyc();
        n_tests++; if (err_flags !== 14'h0) begin n_fail++; $display("FAIL tmo_early got %h exp 0000", err_flags); end
        cyc();
        n_tests++; if (err_flags !== 14'h2000) begin n_fail++; $display("FAIL tmo_flags got %h exp 2000", err_flags); end
        n_tests++; if (first_err_code !== 4'd13 || err_count !== 8'd1) begin n_fail++; $display("FAIL tmo_code got %0d/%0d exp 13/1", first_err_code, err_count); end
        for (int k = 0; k < 4; k++) cyc();
        ARREADY = 1;
        cyc();
        idle_bus();
        cyc();
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL tmo_once got %0d exp 1", err_count); end
        n_tests++; if (dut.ar_out_q !== 3'd1) begin n_fail++; $display("FAIL tmo_ar_out got %0d exp 1", dut.ar_out_q); end
    endtask

    task automatic test_r_unexpected();
        do_reset();
        cyc();
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h300;
        RVALID = 1; RREADY = 1; RDATA = 32'h55; RRESP = 2'b00;
        cyc();
        idle_bus();
        n_tests++; if (err_flags !== 14'h0800) begin n_fail++; $display("FAIL r_unexp_flags got %h exp 0800", err_flags); end
        n_tests++; if (dut.ar_out_q !== 3'd1) begin n_fail++; $display("FAIL r_unexp_ar_out got %0d exp 1", dut.ar_out_q); end
        n_tests++; if (first_err_code !== 4'd11) begin n_fail++; $display("FAIL r_unexp_code got %0d exp 11", first_err_code); end
    endtask

    task automatic test_outst_ovf();
        do_reset();
        ARVALID = 1; ARREADY = 1;
        for (int k = 0; k < 4; k++) begin
            ARADDR = 32'(k * 4);
            cyc();
        end
        n_tests++; if (err_flags !== 14'h0 || dut.ar_out_q !== 3'd4) begin n_fail++; $display("FAIL ovf_pre got %h/%0d exp 0000/4", err_flags, dut.ar_out_q); end
        ARADDR = 32'h10;
        cyc();
        idle_bus();
        n_tests++; if (err_flags !== 14'h1000) begin n_fail++; $display("FAIL ovf_flags got %h exp 1000", err_flags); end
        n_tests++; if (dut.ar_out_q !== 3'd4) begin n_fail++; $display("FAIL ovf_ar_out got %0d exp 4", dut.ar_out_q); end
        n_tests++; if (first_err_code !== 4'd12) begin n_fail++; $display("FAIL ovf_code got %0d exp 12", first_err_code); end
    endtask

    task automatic test_err_clr();
        do_reset();
        // write handshake plus an unexpected R: error cycle 1
        AWVALID = 1; AWREADY = 1; AWADDR = 32'h500;
        WVALID = 1; WREADY = 1; WDATA = 32'h77; WSTRB = 4'hF;
        RVALID = 1; RREADY = 1;
        cyc();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0;
        BVALID = 1; BREADY = 0; BRESP = 2'b00;
        cyc();
        cyc();
        n_tests++; if (err_flags !== 14'h0800 || err_count !== 8'd3) begin n_fail++; $display("FAIL clr_pre got %h/%0d exp 0800/3", err_flags, err_count); end
        // B drops while pending, in the same cycle as the clear
        BVALID = 0; RVALID = 0; RREADY = 0; err_clr = 1;
        cyc();
        err_clr = 0;
        n_tests++; if (err_flags !== 14'h0020) begin n_fail++; $display("FAIL clr_flags got %h exp 0020", err_flags); end
        n_tests++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL clr_count got %0d exp 1", err_count); end
        n_tests++; if (first_err_code !== 4'd5 || first_err_valid !== 1'b1) begin n_fail++; $display("FAIL clr_code got %0d/%b exp 5/1", first_err_code, first_err_valid); end
        err_clr = 1;
        cyc();
        err_clr = 0;
        n_tests++; if (err_flags !== 14'h0 || err_count !== 8'd0 || first_err_valid !== 1'b0) begin n_fail++; $display("FAIL clr_idle got %h/%0d/%b exp 0000/0/0", err_flags, err_count, first_err_valid); end
        n_tests++; if (dut.aw_out_q !== 3'd1) begin n_fail++; $display("FAIL clr_keeps_cnt got %0d exp 1", dut.aw_out_q); end
    endtask

    initial begin
        rst = 1;
        idle_bus();
        test_reset();
        test_legal_write();
        test_payload_chg();
        test_valid_drop();
        test_timeout();
        test_r_unexpected();
        test_outst_ovf();
        test_err_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
